// File: rtl/e203_itcm_icb_ctrl.sv
// ITCM ICB slave: drives a 1-cycle-latency single-port SRAM and returns in-order responses through a small bypassable FIFO.
// Optional: define E203_ITCM_ADDR_CHK_EN to answer out-of-range addresses with an error response.
`timescale 1ns/1ps

module e203_itcm_icb_ctrl #(
    parameter int unsigned ITCM_AW   = 16,
    parameter int unsigned DW        = 64,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 icb_cmd_valid,
    output logic                 icb_cmd_ready,
    input  logic [31:0]          icb_cmd_addr,
    input  logic                 icb_cmd_read,
    input  logic [DW-1:0]        icb_cmd_wdata,
    input  logic [7:0]           icb_cmd_wmask,
    output logic                 icb_rsp_valid,
    input  logic                 icb_rsp_ready,
    output logic                 icb_rsp_err,
    output logic [DW-1:0]        icb_rsp_rdata,
    output logic                 itcm_holdup,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [ITCM_AW-4:0]   ram_addr,
    output logic [7:0]           ram_wem,
    output logic [DW-1:0]        ram_din,
    input  logic [DW-1:0]        ram_dout
);

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic       cmd_fire;
    logic       addr_err;
    logic       rsp_fire;
    logic       push;
    logic       pop_buf;
    logic       buf_empty;
    logic       inflight;
    logic       inflight_read;
    logic       inflight_err;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    rsp_t       buf_q [RSP_DEPTH];
    rsp_t       cap;
    rsp_t       head;

`ifdef E203_ITCM_ADDR_CHK_EN
    logic unused_addr;
    assign unused_addr = ^icb_cmd_addr[2:0];
    assign addr_err    = |icb_cmd_addr[31:ITCM_AW];
`else
    logic unused_addr;
    assign unused_addr = ^{icb_cmd_addr[31:ITCM_AW], icb_cmd_addr[2:0]};
    assign addr_err    = 1'b0;
`endif

    function automatic logic ptr_inc(input logic p);
        return (RSP_DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // Command side: SRAM is strobed in the same cycle a command is accepted.
    assign cmd_fire = icb_cmd_valid & icb_cmd_ready;
    assign ram_cs   = cmd_fire & ~addr_err;
    assign ram_we   = ~icb_cmd_read;
    assign ram_wem  = icb_cmd_read ? 8'h00 : icb_cmd_wmask;
    assign ram_addr = icb_cmd_addr[ITCM_AW-1:3];
    assign ram_din  = icb_cmd_wdata;

    // SRAM output is only meaningful the cycle after a read strobe.
    assign cap.err   = inflight_err;
    assign cap.rdata = inflight_read ? ram_dout : '0;

    assign buf_empty     = (count == 2'd0);
    assign head          = buf_empty ? (inflight ? cap : '0) : buf_q[rd_ptr];
    assign icb_rsp_valid = ~buf_empty | inflight;
    assign icb_rsp_err   = head.err;
    assign icb_rsp_rdata = head.rdata;
    assign rsp_fire      = icb_rsp_valid & icb_rsp_ready;

    // An in-flight response bypasses straight out when the FIFO is empty and the IFU takes it.
    assign pop_buf = rsp_fire & ~buf_empty;
    assign push    = inflight & ~(rsp_fire & buf_empty);

    // Accept only if every outstanding response still has a slot after this cycle's pop.
    assign icb_cmd_ready = (32'(count) + 32'(inflight)) < (RSP_DEPTH + 32'(rsp_fire));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_read <= 1'b0;
            inflight_err  <= 1'b0;
            itcm_holdup   <= 1'b0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
        end else begin
            inflight      <= cmd_fire;
            inflight_read <= cmd_fire & icb_cmd_read & ~addr_err;
            inflight_err  <= cmd_fire & addr_err;
            if (cmd_fire) begin
                itcm_holdup <= icb_cmd_read & ~addr_err;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_buf) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + 2'(push) - 2'(pop_buf);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= cap;
        end
    end

endmodule

// File: tb/tb_e203_itcm_icb_ctrl.sv
// Randomized bench for e203_itcm_icb_ctrl against a transaction-level model (outstanding-response queue + reference memory).
`timescale 1ns/1ps

module tb_e203_itcm_icb_ctrl;

    localparam int unsigned ITCM_AW   = 16;
    localparam int unsigned DW        = 64;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned NW        = 1 << (ITCM_AW - 3);

    logic                clk;
    logic                rst;
    logic                icb_cmd_valid;
    logic                icb_cmd_ready;
    logic [31:0]         icb_cmd_addr;
    logic                icb_cmd_read;
    logic [DW-1:0]       icb_cmd_wdata;
    logic [7:0]          icb_cmd_wmask;
    logic                icb_rsp_valid;
    logic                icb_rsp_ready;
    logic                icb_rsp_err;
    logic [DW-1:0]       icb_rsp_rdata;
    logic                itcm_holdup;
    logic                ram_cs;
    logic                ram_we;
    logic [ITCM_AW-4:0]  ram_addr;
    logic [7:0]          ram_wem;
    logic [DW-1:0]       ram_din;
    logic [DW-1:0]       ram_dout;

    e203_itcm_icb_ctrl #(
        .ITCM_AW  (ITCM_AW),
        .DW       (DW),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icb_cmd_valid(icb_cmd_valid),
        .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr (icb_cmd_addr),
        .icb_cmd_read (icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata),
        .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid),
        .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err  (icb_rsp_err),
        .icb_rsp_rdata(icb_rsp_rdata),
        .itcm_holdup  (itcm_holdup),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wem      (ram_wem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        if (i == 1) return 64'h1122_3344_5566_7788;
        return {32'(i) * 32'h9E37_79B9, ~32'(i)};
    endfunction

    // SRAM macro model: driven only by the DUT's ram_* pins.
    logic [63:0] sram [NW];
    initial begin
        for (int i = 0; i < int'(NW); i++) sram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_cs) begin
                if (ram_we) begin
                    for (int b = 0; b < 8; b++)
                        if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end else begin
                    ram_dout <= sram[ram_addr];
                end
            end
        end
    end

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    logic [63:0] refm [NW];
    exp_t        q [$];
    logic        hold_exp;
    int          n_pass;
    int          n_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef E203_ITCM_ADDR_CHK_EN
        return a[31:ITCM_AW] != '0;
`else
        return (a & 32'h0) != 32'h0;
`endif
    endfunction

    // One bus cycle: drive, check against the model, then advance the model.
    task automatic step(input logic v, input logic rd, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] wm, input logic rr);
        logic exp_valid, pop, exp_ready, bad, exp_cs;
        int   w;
        exp_t r;
        @(negedge clk);
        icb_cmd_valid = v;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        icb_rsp_ready = rr;
        #1;
        exp_valid = q.size() > 0;
        pop       = exp_valid && rr;
        exp_ready = (q.size() - (pop ? 1 : 0)) < int'(RSP_DEPTH);
        bad       = addr_bad(a);
        exp_cs    = v && exp_ready && !bad;
        w         = int'(a[ITCM_AW-1:3]);
        check("cmd_ready", 64'(icb_cmd_ready), 64'(exp_ready));
        check("rsp_valid", 64'(icb_rsp_valid), 64'(exp_valid));
        if (exp_valid && icb_rsp_valid) begin
            check("rsp_rdata", icb_rsp_rdata, q[0].d);
            check("rsp_err", 64'(icb_rsp_err), 64'(q[0].e));
        end
        check("holdup", 64'(itcm_holdup), 64'(hold_exp));
        check("ram_cs", 64'(ram_cs), 64'(exp_cs));
        if (exp_cs && ram_cs) begin
            check("ram_addr", 64'(ram_addr), 64'(w));
            check("ram_we", 64'(ram_we), 64'(!rd));
            if (!rd) begin
                check("ram_wem", 64'(ram_wem), 64'(wm));
                check("ram_din", ram_din, wd);
            end
        end
        if (pop) void'(q.pop_front());
        if (v && exp_ready) begin
            r.e = bad;
            r.d = 64'h0;
            if (!bad && rd) r.d = refm[w];
            if (!bad && !rd)
                for (int b = 0; b < 8; b++)
                    if (wm[b]) refm[w][8*b +: 8] = wd[8*b +: 8];
            q.push_back(r);
            hold_exp = rd && !bad;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 32'h0, 64'h0, 8'h0, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(icb_rsp_valid), 64'h0);
        check("rst_holdup", 64'(itcm_holdup), 64'h0);
        check("rst_rsp_err", 64'(icb_rsp_err), 64'h0);
        check("rst_rsp_rdata", icb_rsp_rdata, 64'h0);
        q.delete();
        hold_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        n_pass   = 0;
        n_total  = 0;
        hold_exp = 1'b0;
        for (int i = 0; i < int'(NW); i++) refm[i] = init_word(i);
        rst           = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 64'h0;
        icb_cmd_wmask = 8'h0;
        icb_rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(icb_rsp_valid), 64'h0);
        check("rst_holdup", 64'(itcm_holdup), 64'h0);
        check("rst_ram_cs", 64'(ram_cs), 64'h0);
        check("rst_rsp_rdata", icb_rsp_rdata, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single read of word 1, then idle so holdup persists.
        step(1'b1, 1'b1, 32'h8, 64'h0, 8'h0, 1'b1);
        idle(3, 1'b1);

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(8 * i), 64'h0, 8'h0, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: only two accepted while the IFU stalls.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(8 * i + 8), 64'h0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h28, 64'h0, 8'h0, 1'b1);
        idle(3, 1'b1);

        // Write clears holdup; read back the merged word.
        step(1'b1, 1'b0, 32'h20, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 32'h20, 64'h0, 8'h0, 1'b1);
        idle(2, 1'b1);

        // Reset with two responses pending.
        step(1'b1, 1'b1, 32'h0, 64'h0, 8'h0, 1'b0);
        step(1'b1, 1'b1, 32'h8, 64'h0, 8'h0, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(3, 1'b1);

`ifdef E203_ITCM_ADDR_CHK_EN
        step(1'b1, 1'b1, 32'h8, 64'h0, 8'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0001_0000, 64'h0, 8'h0, 1'b1);
        idle(2, 1'b1);
`endif

        // Random traffic over a small window so reads hit earlier writes.
        for (int i = 0; i < 3000; i++) begin
            a = 32'($urandom_range(0, 15) * 8) | 32'($urandom_range(0, 7));
`ifdef E203_ITCM_ADDR_CHK_EN
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 255)) << ITCM_AW);
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, a,
                 {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(4, 1'b1);
        check("drained", 64'(q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
